// File: rtl/medidor_frecuencia_pkg.sv
// Shared types and default constants for the slow-clock frequency meter.
package medidor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2,
      LOST    = 2'd3
   } med_state_t;

   // Defaults match a divider producing a 21000-cycle half-period on C_50Mhz.
   localparam int unsigned CNT_W_DEF         = 25;
   localparam int unsigned SYNC_STAGES_DEF   = 2;
   localparam int unsigned EXPECTED_HALF_DEF = 21000;
   localparam int unsigned TOLERANCE_DEF     = 2;
   localparam int unsigned LOCK_COUNT_DEF    = 4;
   localparam int unsigned TIMEOUT_DEF       = 84000;

endpackage

// File: rtl/medidor_frecuencia_sincronizador.sv
// Brings the asynchronous slow clock into the C_50Mhz domain and flags every
// transition of the synchronized level with a one-cycle edge_pulse.
module sincronizador_flanco #(
   parameter int unsigned SYNC_STAGES = 2
)(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_d;

   // Metastability chain, then the level flop and its one-cycle delayed copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
         level   <= sync_q[SYNC_STAGES-1];
         level_d <= level;
      end
   end

   // Either direction of transition counts as an edge.
   assign edge_pulse = level ^ level_d;

endmodule

// File: rtl/medidor_frecuencia.sv
// Measures each half-period of a slow divided clock and tracks lock/loss.
//
// Handshake: meas_valid is a one-cycle strobe with no ready; half_period and
// in_range are stable from the strobe cycle until the next strobe or a clear.
module medidor_frecuencia
   import medidor_pkg::*;
#(
   parameter int unsigned CNT_W         = CNT_W_DEF,
   parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int unsigned EXPECTED_HALF = EXPECTED_HALF_DEF,
   parameter int unsigned TOLERANCE     = TOLERANCE_DEF,
   parameter int unsigned LOCK_COUNT    = LOCK_COUNT_DEF,
   parameter int unsigned TIMEOUT       = TIMEOUT_DEF
)(
   input  logic             C_50Mhz,
   input  logic             rst_n,
   input  logic             clk_in,
   input  logic             clear,
   output logic             edge_pulse,
   output logic             level,
   output logic [CNT_W-1:0] half_period,
   output logic             meas_valid,
   output logic             in_range,
   output logic             locked,
   output logic             lost,
   output med_state_t       state_dbg
);

   localparam int unsigned LOCK_W = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0]  WIN_LO      = CNT_W'(EXPECTED_HALF - TOLERANCE);
   localparam logic [CNT_W-1:0]  WIN_HI      = CNT_W'(EXPECTED_HALF + TOLERANCE);
   localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
   localparam logic [LOCK_W-1:0] LOCK_TARGET = LOCK_W'(LOCK_COUNT);

   med_state_t        state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic [LOCK_W-1:0] lock_cnt, lock_cnt_next, lock_inc;
   logic              cnt_ok;
   logic              publish;

   sincronizador_flanco #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk        (C_50Mhz),
      .rst_n      (rst_n),
      .d          (clk_in),
      .level      (level),
      .edge_pulse (edge_pulse)
   );

   assign cnt_ok   = (cnt >= WIN_LO) && (cnt <= WIN_HI);
   assign lock_inc = lock_cnt + LOCK_W'(1);

   // State register and consecutive in-range counter.
   always_ff @(posedge C_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lock_cnt <= '0;
      end else begin
         state    <= state_next;
         lock_cnt <= lock_cnt_next;
      end
   end

   // Next state; an edge always beats a timeout landing on the same cycle.
   always_comb begin
      state_next    = state;
      lock_cnt_next = lock_cnt;
      publish       = 1'b0;
      if (clear) begin
         state_next    = IDLE;
         lock_cnt_next = '0;
      end else begin
         unique case (state)
            IDLE: begin
               // The first edge only gives the counter a starting point.
               if (edge_pulse) state_next = MEASURE;
            end
            MEASURE: begin
               if (edge_pulse) begin
                  publish = 1'b1;
                  if (cnt_ok) begin
                     lock_cnt_next = lock_inc;
                     if (lock_inc == LOCK_TARGET) state_next = LOCKED;
                  end else begin
                     lock_cnt_next = '0;
                  end
               end else if (cnt == TIMEOUT_C) begin
                  state_next    = LOST;
                  lock_cnt_next = '0;
               end
            end
            LOCKED: begin
               if (edge_pulse) begin
                  publish = 1'b1;
                  if (!cnt_ok) begin
                     state_next    = MEASURE;
                     lock_cnt_next = '0;
                  end
               end else if (cnt == TIMEOUT_C) begin
                  state_next    = LOST;
                  lock_cnt_next = '0;
               end
            end
            LOST: begin
               // The count spans the stall, so this edge is not published.
               if (edge_pulse) begin
                  state_next    = MEASURE;
                  lock_cnt_next = '0;
               end
            end
            default: begin
               state_next    = IDLE;
               lock_cnt_next = '0;
            end
         endcase
      end
   end

   // Half-period counter and published measurement registers.
   always_ff @(posedge C_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         half_period <= '0;
         meas_valid  <= 1'b0;
         in_range    <= 1'b0;
      end else if (clear) begin
         cnt         <= '0;
         half_period <= '0;
         meas_valid  <= 1'b0;
         in_range    <= 1'b0;
      end else begin
         meas_valid <= publish;
         if (publish) begin
            half_period <= cnt;
            in_range    <= cnt_ok;
         end
         if (edge_pulse) begin
            cnt <= CNT_W'(1);
         end else if (state != IDLE && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign locked    = (state == LOCKED);
   assign lost      = (state == LOST);
   assign state_dbg = state;

endmodule

// File: tb/tb_medidor_frecuencia.sv
// Directed bench for medidor_frecuencia with scaled-down timing parameters.
module tb_medidor_frecuencia;
   import medidor_pkg::*;

   localparam int unsigned CNT_W_T   = 8;
   localparam int unsigned EXP_T     = 20;
   localparam int unsigned TOL_T     = 2;
   localparam int unsigned LOCK_T    = 4;
   localparam int unsigned TIMEOUT_T = 80;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clk_in;
   logic             clear;
   logic             edge_pulse;
   logic             level;
   logic [CNT_W_T-1:0] half_period;
   logic             meas_valid;
   logic             in_range;
   logic             locked;
   logic             lost;
   med_state_t       state_dbg;

   int total = 0;
   int bad   = 0;

   medidor_frecuencia #(
      .CNT_W         (CNT_W_T),
      .SYNC_STAGES   (2),
      .EXPECTED_HALF (EXP_T),
      .TOLERANCE     (TOL_T),
      .LOCK_COUNT    (LOCK_T),
      .TIMEOUT       (TIMEOUT_T)
   ) dut (
      .C_50Mhz     (clk),
      .rst_n       (rst_n),
      .clk_in      (clk_in),
      .clear       (clear),
      .edge_pulse  (edge_pulse),
      .level       (level),
      .half_period (half_period),
      .meas_valid  (meas_valid),
      .in_range    (in_range),
      .locked      (locked),
      .lost        (lost),
      .state_dbg   (state_dbg)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Observation monitor: records events on the falling edge, away from updates.
   int               ep_count      = 0;
   int               ep_cyc        = 0;
   int               mv_count      = 0;
   logic [CNT_W_T-1:0] mv_last     = '0;
   int               lock_rise_mv  = 0;
   int               lock_rise_cnt = 0;
   int               lost_rise_cyc = 0;
   int               lost_rise_cnt = 0;
   logic             locked_q      = 1'b0;
   logic             lost_q        = 1'b0;

   always @(negedge clk) begin
      if (edge_pulse === 1'b1) begin
         ep_count++;
         ep_cyc = cyc;
      end
      if (meas_valid === 1'b1) begin
         mv_count++;
         mv_last = half_period;
      end
      if (locked === 1'b1 && !locked_q) begin
         lock_rise_mv = mv_count;
         lock_rise_cnt++;
      end
      if (lost === 1'b1 && !lost_q) begin
         lost_rise_cyc = cyc;
         lost_rise_cnt++;
      end
      locked_q = (locked === 1'b1);
      lost_q   = (lost === 1'b1);
   end

   // Watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks.
   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic toggle_wait(input int n);
      clk_in = ~clk_in;
      cyc_wait(n);
   endtask

   task automatic restart();
      clear  = 1'b0;
      clk_in = 1'b0;
      rst_n  = 1'b0;
      cyc_wait(4);
      rst_n = 1'b1;
      cyc_wait(4);
   endtask

   task automatic lock_nominal();
      restart();
      repeat (5) toggle_wait(EXP_T);
   endtask

   task automatic test_reset();
      int base_ep;
      rst_n = 1'b0; clear = 1'b0; clk_in = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         clk_in = ~clk_in;
      end
      cyc_wait(1);
      total++; if (edge_pulse !== 1'b0) begin bad++; $display("FAIL reset_edge_pulse: got %0b expected 0", edge_pulse); end
      total++; if (level !== 1'b0) begin bad++; $display("FAIL reset_level: got %0b expected 0", level); end
      total++; if (half_period !== '0) begin bad++; $display("FAIL reset_half_period: got %0d expected 0", half_period); end
      total++; if ({meas_valid, in_range, locked, lost} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b expected 0000", {meas_valid, in_range, locked, lost}); end
      total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
      rst_n = 1'b1;
      base_ep = ep_count;
      cyc_wait(6);
      total++; if (ep_count !== base_ep) begin bad++; $display("FAIL reset_no_edge: got %0d edges expected 0", ep_count - base_ep); end
      clk_in = 1'b1;
      cyc_wait(1);
      total++; if (edge_pulse !== 1'b0) begin bad++; $display("FAIL latency_c1: got %0b expected 0", edge_pulse); end
      cyc_wait(1);
      total++; if (edge_pulse !== 1'b0) begin bad++; $display("FAIL latency_c2: got %0b expected 0", edge_pulse); end
      cyc_wait(1);
      total++; if (edge_pulse !== 1'b1) begin bad++; $display("FAIL latency_c3: got %0b expected 1", edge_pulse); end
      cyc_wait(1);
      total++; if (edge_pulse !== 1'b0) begin bad++; $display("FAIL latency_c4: got %0b expected 0", edge_pulse); end
      total++; if (state_dbg !== MEASURE || meas_valid !== 1'b0 || level !== 1'b1) begin bad++; $display("FAIL first_edge: got state=%0d mv=%0b level=%0b expected state=1 mv=0 level=1", state_dbg, meas_valid, level); end
   endtask

   task automatic test_nominal();
      int base;
      restart();
      base = mv_count;
      repeat (6) toggle_wait(EXP_T);
      total++; if (mv_count - base !== 5) begin bad++; $display("FAIL nominal_meas_count: got %0d expected 5", mv_count - base); end
      total++; if (mv_last !== 8'd20 || half_period !== 8'd20) begin bad++; $display("FAIL nominal_half: got %0d/%0d expected 20", mv_last, half_period); end
      total++; if (in_range !== 1'b1) begin bad++; $display("FAIL nominal_in_range: got %0b expected 1", in_range); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL nominal_locked: got %0b expected 1", locked); end
      total++; if (lock_rise_mv - base !== 4) begin bad++; $display("FAIL nominal_lock_point: got meas %0d expected 4", lock_rise_mv - base); end
   endtask

   task automatic test_off_frequency();
      int base, base_lock;
      restart();
      base = mv_count; base_lock = lock_rise_cnt;
      repeat (5) toggle_wait(EXP_T + 3);
      total++; if (mv_last !== 8'd23 || in_range !== 1'b0) begin bad++; $display("FAIL off_half: got %0d in_range=%0b expected 23 in_range=0", mv_last, in_range); end
      total++; if (locked !== 1'b0 || lock_rise_cnt !== base_lock) begin bad++; $display("FAIL off_never_locked: got locked=%0b rises=%0d expected 0 0", locked, lock_rise_cnt - base_lock); end
      repeat (5) toggle_wait(EXP_T + 2);
      total++; if (locked !== 1'b1 || lock_rise_mv - base !== 9) begin bad++; $display("FAIL off_relock: got locked=%0b at meas %0d expected 1 at 9", locked, lock_rise_mv - base); end
      total++; if (mv_last !== 8'd22 || in_range !== 1'b1) begin bad++; $display("FAIL off_edge_tol: got %0d in_range=%0b expected 22 in_range=1", mv_last, in_range); end
      toggle_wait(EXP_T - 3);
      toggle_wait(EXP_T);
      total++; if (mv_last !== 8'd17 || in_range !== 1'b0) begin bad++; $display("FAIL short_half: got %0d in_range=%0b expected 17 in_range=0", mv_last, in_range); end
      total++; if (locked !== 1'b0 || state_dbg !== MEASURE) begin bad++; $display("FAIL short_unlock: got locked=%0b state=%0d expected 0 1", locked, state_dbg); end
   endtask

   task automatic test_stall();
      int base;
      lock_nominal();
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL stall_pre_lock: got %0b expected 1", locked); end
      cyc_wait(100);
      total++; if (lost !== 1'b1 || locked !== 1'b0 || state_dbg !== LOST) begin bad++; $display("FAIL stall_lost: got lost=%0b locked=%0b state=%0d expected 1 0 3", lost, locked, state_dbg); end
      // cnt reaches TIMEOUT in the TIMEOUT-th cycle after the edge cycle; LOST registers one edge later.
      total++; if (lost_rise_cyc - ep_cyc !== TIMEOUT_T + 1) begin bad++; $display("FAIL stall_timing: got %0d expected %0d", lost_rise_cyc - ep_cyc, TIMEOUT_T + 1); end
      base = mv_count;
      toggle_wait(EXP_T);
      total++; if (mv_count !== base || state_dbg !== MEASURE || lost !== 1'b0) begin bad++; $display("FAIL resume_discard: got meas=%0d state=%0d lost=%0b expected 0 1 0", mv_count - base, state_dbg, lost); end
      repeat (4) toggle_wait(EXP_T);
      total++; if (locked !== 1'b1 || lock_rise_mv - base !== 4 || mv_last !== 8'd20) begin bad++; $display("FAIL resume_relock: got locked=%0b at meas %0d half=%0d expected 1 at 4 half=20", locked, lock_rise_mv - base, mv_last); end
   endtask

   task automatic test_clear();
      int base;
      lock_nominal();
      clear = 1'b1;
      cyc_wait(1);
      clear = 1'b0;
      total++; if (locked !== 1'b0 || half_period !== '0 || in_range !== 1'b0 || state_dbg !== IDLE) begin bad++; $display("FAIL clear_state: got locked=%0b half=%0d in_range=%0b state=%0d expected 0 0 0 0", locked, half_period, in_range, state_dbg); end
      base = mv_count;
      toggle_wait(EXP_T);
      total++; if (mv_count !== base || state_dbg !== MEASURE) begin bad++; $display("FAIL clear_first_edge: got meas=%0d state=%0d expected 0 1", mv_count - base, state_dbg); end
      toggle_wait(EXP_T);
      total++; if (mv_count - base !== 1 || mv_last !== 8'd20) begin bad++; $display("FAIL clear_second_edge: got meas=%0d half=%0d expected 1 20", mv_count - base, mv_last); end
      // Clear lands on the edge_pulse cycle.
      clk_in = ~clk_in;
      cyc_wait(3);
      total++; if (edge_pulse !== 1'b1) begin bad++; $display("FAIL clear_edge_align: got %0b expected 1", edge_pulse); end
      clear = 1'b1;
      cyc_wait(1);
      clear = 1'b0;
      total++; if (state_dbg !== IDLE || mv_count - base !== 1 || meas_valid !== 1'b0) begin bad++; $display("FAIL clear_beats_edge: got state=%0d meas=%0d mv=%0b expected 0 1 0", state_dbg, mv_count - base, meas_valid); end
      cyc_wait(16);
      toggle_wait(EXP_T);
      total++; if (state_dbg !== MEASURE || mv_count - base !== 1) begin bad++; $display("FAIL clear_edge_restart: got state=%0d meas=%0d expected 1 1", state_dbg, mv_count - base); end
   endtask

   task automatic test_async_reset();
      int base;
      lock_nominal();
      toggle_wait(8);
      total++; if (locked !== 1'b1 || half_period !== 8'd20) begin bad++; $display("FAIL arst_pre: got locked=%0b half=%0d expected 1 20", locked, half_period); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({locked, in_range, meas_valid, lost, edge_pulse} !== 5'b0 || half_period !== '0 || state_dbg !== IDLE) begin bad++; $display("FAIL arst_immediate: got flags=%b half=%0d state=%0d expected 00000 0 0", {locked, in_range, meas_valid, lost, edge_pulse}, half_period, state_dbg); end
      restart();
      base = mv_count;
      toggle_wait(EXP_T);
      total++; if (mv_count !== base || state_dbg !== MEASURE) begin bad++; $display("FAIL arst_first_edge: got meas=%0d state=%0d expected 0 1", mv_count - base, state_dbg); end
   endtask

   task automatic test_corner();
      int base, base_lost;
      restart();
      base_lost = lost_rise_cnt;
      toggle_wait(TIMEOUT_T);
      toggle_wait(10);
      total++; if (lost_rise_cnt !== base_lost || state_dbg !== MEASURE) begin bad++; $display("FAIL timeout_edge_no_lost: got rises=%0d state=%0d expected 0 1", lost_rise_cnt - base_lost, state_dbg); end
      total++; if (mv_last !== 8'(TIMEOUT_T) || in_range !== 1'b0) begin bad++; $display("FAIL timeout_edge_half: got %0d in_range=%0b expected %0d 0", mv_last, in_range, TIMEOUT_T); end
      lock_nominal();
      base = mv_count;
      clk_in = ~clk_in;
      cyc_wait(1);
      clk_in = ~clk_in;
      cyc_wait(EXP_T);
      total++; if (mv_count - base !== 2 || mv_last !== 8'd1 || in_range !== 1'b0) begin bad++; $display("FAIL glitch_meas: got meas=%0d half=%0d in_range=%0b expected 2 1 0", mv_count - base, mv_last, in_range); end
      total++; if (locked !== 1'b0 || state_dbg !== MEASURE) begin bad++; $display("FAIL glitch_unlock: got locked=%0b state=%0d expected 0 1", locked, state_dbg); end
   endtask

   // Test sequence and final report.
   initial begin
      rst_n  = 1'b0;
      clear  = 1'b0;
      clk_in = 1'b0;
      test_reset();
      test_nominal();
      test_off_frequency();
      test_stall();
      test_clear();
      test_async_reset();
      test_corner();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
